// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter and sequencer for a single memory port, one transaction outstanding.
// Optional round-robin arbitration when MEM_ARBITER_RR_EN is defined; fixed LSU-over-IFU otherwise.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_rdata,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {GNT_IFU = 1'b0, GNT_LSU = 1'b1} grant_e;

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_wen_q, mem_wen_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0] mem_wmask_q, mem_wmask_d;
    logic            ifu_resp_valid_q, ifu_resp_valid_d;
    logic            lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DW-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DW-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic            lsu_wins;
    logic            in_idle;

    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        // On a tie the master not granted last time wins.
        if (lsu_req_valid && ifu_req_valid) lsu_wins = (grant_q == GNT_IFU);
        else                                lsu_wins = lsu_req_valid;
`else
        lsu_wins = lsu_req_valid;
`endif
    end

    // Ready is gated by rst so that every output reads 0 while reset is held.
    assign in_idle       = rst && (state_q == IDLE);
    assign lsu_req_ready = in_idle && lsu_wins;
    assign ifu_req_ready = in_idle && !lsu_wins && ifu_req_valid;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d          = state_q;
        grant_d          = grant_q;
        cnt_d            = cnt_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_addr_d       = mem_addr_q;
        mem_wen_d        = mem_wen_q;
        mem_wdata_d      = mem_wdata_q;
        mem_wmask_d      = mem_wmask_q;
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;
        ifu_rdata_d      = '0;
        lsu_rdata_d      = '0;
        resp_err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_ready) begin
                    mem_addr_d      = lsu_addr;
                    mem_wen_d       = lsu_wen;
                    mem_wdata_d     = lsu_wdata;
                    mem_wmask_d     = lsu_wmask;
                    grant_d         = GNT_LSU;
                    mem_req_valid_d = 1'b1;
                    state_d         = REQ;
                end else if (ifu_req_ready) begin
                    mem_addr_d      = ifu_addr;
                    mem_wen_d       = 1'b0;
                    mem_wdata_d     = '0;
                    mem_wmask_d     = '0;
                    grant_d         = GNT_IFU;
                    mem_req_valid_d = 1'b1;
                    state_d         = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                // A real response wins over a coincident timeout.
                if (mem_resp_valid || cnt_q >= CW'(TIMEOUT)) begin
                    state_d    = IDLE;
                    resp_err_d = !mem_resp_valid;
                    if (grant_q == GNT_LSU) begin
                        lsu_resp_valid_d = 1'b1;
                        lsu_rdata_d      = (mem_resp_valid && !mem_wen_q) ? mem_rdata : '0;
                    end else begin
                        ifu_resp_valid_d = 1'b1;
                        ifu_rdata_d      = mem_resp_valid ? mem_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            grant_q          <= GNT_IFU;
            cnt_q            <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
            resp_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            cnt_q            <= cnt_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wen_q        <= mem_wen_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_wmask_q      <= mem_wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
            resp_err_q       <= resp_err_d;
        end
    end

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wen        = mem_wen_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wmask      = mem_wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign resp_err       = resp_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT = 4): single read, tie, stall, timeout, reset.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        resp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

        // Reset state: outputs 0 even with a request pending.
        tick(); tick();
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_ifu_resp",  ifu_resp_valid, 0);
        rst = 1'b1;
        #1;

        // Single IFU read.
        check("t1_ifu_ready", ifu_req_ready, 1);
        check("t1_lsu_ready", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("t1_mem_valid", mem_req_valid, 1);
        check("t1_mem_addr",  mem_addr, 32'h8000_0000);
        check("t1_mem_wen",   mem_wen, 0);
        check("t1_mem_wmask", mem_wmask, 0);
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        #1;
        check("t1_valid_drop", mem_req_valid, 0);
        check("t1_no_early",   ifu_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        check("t1_ifu_resp",  ifu_resp_valid, 1);
        check("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        check("t1_err",       resp_err, 0);
        check("t1_lsu_resp",  lsu_resp_valid, 0);
        tick();
        check("t1_pulse_end", ifu_resp_valid, 0);

        // Tie: IFU read vs LSU write, LSU wins first.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        check("t2_lsu_ready", lsu_req_ready, 1);
        check("t2_ifu_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("t2_mem_wen",   mem_wen, 1);
        check("t2_mem_addr",  mem_addr, 32'h8000_1000);
        check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t2_mem_wmask", mem_wmask, 4'hF);
        check("t2_ifu_wait",  ifu_req_ready, 0);
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        // Second tie presented in the response cycle.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        #1;
        check("t2_lsu_resp",  lsu_resp_valid, 1);
        check("t2_lsu_rdata", lsu_rdata, 0);
        check("t2_err",       resp_err, 0);
        check("t2_ifu_resp",  ifu_resp_valid, 0);
`ifdef MEM_ARBITER_RR_EN
        check("t2_rr_ifu_ready", ifu_req_ready, 1);
        check("t2_rr_lsu_ready", lsu_req_ready, 0);
`else
        check("t2_fp_lsu_ready", lsu_req_ready, 1);
        check("t2_fp_ifu_ready", ifu_req_ready, 0);
`endif
        lsu_req_valid = 1'b0;
        #1;
        check("t2_ifu_next", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        check("t2_ifu_addr",  mem_addr, 32'h8000_0004);
        check("t2_ifu_wen",   mem_wen, 0);
        check("t2_ifu_wdata", mem_wdata, 0);
        check("t2_ifu_wmask", mem_wmask, 0);

        // Stall: mem_req_ready low for 5 cycles while LSU waits.
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_valid", mem_req_valid, 1);
            check("t3_stall_addr",  mem_addr, 32'h8000_0004);
            check("t3_stall_lsu",   lsu_req_ready, 0);
            check("t3_stall_ifu",   ifu_req_ready, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check("t3_wait_lsu", lsu_req_ready, 0);
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        check("t3_ifu_resp",  ifu_resp_valid, 1);
        check("t3_ifu_rdata", ifu_rdata, 32'hCAFE_F00D);
        check("t3_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("t3_lsu_addr", mem_addr, 32'h8000_2000);
        check("t3_lsu_wen",  mem_wen, 0);

        // Timeout: memory never answers; counter 0..4 in WAIT, error on fifth WAIT edge.
        tick();
        mem_req_ready = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_no_resp", lsu_resp_valid, 0);
        end
        tick();
        check("t4_lsu_resp",  lsu_resp_valid, 1);
        check("t4_err",       resp_err, 1);
        check("t4_lsu_rdata", lsu_rdata, 0);
        check("t4_ifu_resp",  ifu_resp_valid, 0);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        #1;
        check("t4_accept_new", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        check("t4_new_valid", mem_req_valid, 1);
        check("t4_err_clear", resp_err, 0);

        // Response coincides with timeout: response wins.
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        check("t4b_ifu_resp",  ifu_resp_valid, 1);
        check("t4b_err",       resp_err, 0);
        check("t4b_ifu_rdata", ifu_rdata, 32'h55AA_55AA);

        // Reset during WAIT of an LSU write.
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b1;
        lsu_wdata = 32'h0BAD_F00D; lsu_wmask = 4'h3;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("t5_mem_valid", mem_req_valid, 0);
        check("t5_mem_addr",  mem_addr, 0);
        check("t5_mem_wen",   mem_wen, 0);
        check("t5_mem_wdata", mem_wdata, 0);
        check("t5_mem_wmask", mem_wmask, 0);
        check("t5_lsu_resp",  lsu_resp_valid, 0);
        tick();
        rst = 1'b1;
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_resp_valid = 1'b0;
        check("t5_late_lsu", lsu_resp_valid, 0);
        check("t5_late_ifu", ifu_resp_valid, 0);
        tick();
        check("t5_late_lsu2", lsu_resp_valid, 0);
        ifu_req_valid = 1'b1;
        #1;
        check("t5_idle_ready", ifu_req_ready, 1);
        check("t5_idle_valid", mem_req_valid, 0);
        ifu_req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name:
mem_arbiter

Overview:
Two-master arbiter and sequencer for the single physical-memory port shared by the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It serialises requests with one transaction outstanding and drives the downstream memory port with a valid/ready request and a response strobe. It returns each response to the master that issued the request and converts a stalled memory into an error response via a watchdog counter.

Parameters:
AW, 32, address width in bits.
DW, 32, data width in bits; the write mask is DW/8 bits wide.
TIMEOUT, 255, maximum cycles spent in WAIT before an error response is forced; must be at least 1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset (0 = reset).
ifu_req_valid  in  1  IFU read request.
ifu_req_ready  out  1  IFU request accepted this cycle.
ifu_addr  in  AW  IFU read address.
ifu_resp_valid  out  1  one-cycle IFU response strobe.
ifu_rdata  out  DW  IFU read data, valid with ifu_resp_valid.
lsu_req_valid  in  1  LSU request.
lsu_req_ready  out  1  LSU request accepted this cycle.
lsu_addr  in  AW  LSU address.
lsu_wen  in  1  1 = write, 0 = read.
lsu_wdata  in  DW  LSU write data.
lsu_wmask  in  DW/8  LSU byte-enable mask.
lsu_resp_valid  out  1  one-cycle LSU response strobe; also issued for writes.
lsu_rdata  out  DW  LSU read data; 0 for writes.
resp_err  out  1  qualifies whichever resp_valid is high; 1 = timeout.
mem_req_valid  out  1  downstream request valid.
mem_req_ready  in  1  downstream request accepted.
mem_addr  out  AW  latched address.
mem_wen  out  1  latched write enable.
mem_wdata  out  DW  latched write data.
mem_wmask  out  DW/8  latched mask; all zeros for IFU requests.
mem_resp_valid  in  1  downstream response strobe.
mem_rdata  in  DW  downstream read data.

Behaviour:
- Reset (asynchronous, rst = 0): state = IDLE; grant register = IFU; timeout counter = 0; every output = 0. An in-flight transaction is discarded and no response is issued for it. A mem_resp_valid arriving after reset is ignored.
- States: IDLE, REQ, WAIT.
- IDLE: the *_req_ready outputs are combinational. Only the arbitration winner sees ready = 1, and only in IDLE. Default arbitration is fixed priority, LSU over IFU.
- IDLE, on a handshake (valid & ready): latch addr, wen, wdata and wmask (IFU: wen = 0, wmask = 0, wdata = 0); record the grant; go to REQ.
- REQ: mem_req_valid = 1 and the mem_* outputs hold the latched values. When mem_req_ready = 1 on a rising edge, go to WAIT and clear the counter. mem_req_valid drops in the cycle after acceptance.
- WAIT: the counter increments each cycle.
  - If mem_resp_valid = 1: the granted master's resp_valid pulses for exactly one cycle on the next clock. rdata = mem_rdata, or 0 for writes. resp_err = 0. Go to IDLE.
  - Else if the counter has reached TIMEOUT: the granted master's resp_valid pulses with rdata = 0 and resp_err = 1. Go to IDLE.
  - mem_resp_valid takes precedence when it coincides with the timeout.
- Latency: minimum 3 cycles from the request handshake to resp_valid (handshake in IDLE, REQ with immediate ready, WAIT with immediate response, registered response).
- A new request can be accepted in the same cycle as resp_valid (the state is IDLE). The non-granted master's resp_valid and rdata stay 0.
- Masters hold their request fields stable while valid = 1 and ready = 0. The arbiter does not buffer more than one request.
- mem_resp_valid outside WAIT is ignored.
- The counter saturates and does not wrap.

Optional Feature:
MEM_ARBITER_RR_EN. When defined, arbitration is round-robin: when both masters request in IDLE, the master that was not granted last wins; the grant register resets to IFU, so LSU wins the first tie. When undefined, arbitration is fixed priority with LSU over IFU, and IFU can be starved by continuous LSU traffic.

Test Plan:
- Single IFU read of addr 0x80000000; mem_req_ready = 1 immediately; mem_resp_valid one cycle later with rdata 0x00000413 -> ifu_resp_valid pulses once with ifu_rdata = 0x00000413, resp_err = 0, 3 cycles after the handshake; lsu_resp_valid stays 0.
- Simultaneous IFU read and LSU write (addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF) -> LSU granted first and mem_wen = 1; lsu_resp_valid pulses with lsu_rdata = 0; IFU granted on the next IDLE. With MEM_ARBITER_RR_EN, a second tie goes to IFU.
- mem_req_ready held low 5 cycles -> mem_req_valid and mem_addr stay stable for those 5 cycles; both *_req_ready stay 0 until the response.
- TIMEOUT = 4 and mem_resp_valid never asserts -> resp_valid pulses with resp_err = 1 and rdata = 0 at the TIMEOUT boundary; the arbiter then accepts a new request.
- Reset asserted during WAIT, with mem_resp_valid arriving one cycle after reset is released -> all outputs are 0 immediately (asynchronously); no resp_valid is issued; state is IDLE.
